cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Common-data-bus (CDB) arbiter for the dynamically scheduled MIPS datapath.
- Functional units, selected per instruction by the decoder's 2-bit functional-unit field, finish out of order. Each unit hands its result (tag + data + overflow flag) to this block.
- The block buffers one result per unit, picks one per cycle round-robin, and broadcasts it on the registered CDB to reservation stations and the register file.

Parameters:
- NREQ, 3, number of requesting functional units (index 0 = ALU/shift, 1 = load/store, 2 = multiplier).
- TAG_W, 4, reservation-station tag width.
- DATA_W, 32, result data width.

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-high reset.
- flush, input, 1, synchronous squash (branch mispredict / exception).
- req_valid, input, NREQ, unit i presents a result.
- req_ready, output, NREQ, unit i's result is accepted this cycle.
- req_tag, input, NREQ*TAG_W, packed tags; unit i occupies bits [i*TAG_W +: TAG_W].
- req_data, input, NREQ*DATA_W, packed results; same packing as req_tag.
- req_ov, input, NREQ, overflow flag per unit.
- cdb_valid, output, 1, broadcast valid.
- cdb_tag, output, TAG_W, broadcast tag.
- cdb_data, output, DATA_W, broadcast data.
- cdb_ov, output, 1, broadcast overflow flag.
- cdb_src, output, 2, index of the unit that won.
- busy, output, 1, any holding buffer full or cdb_valid high.

Behaviour:
- Per unit: one holding buffer (full_i, tag, data, ov).
- Round-robin pointer rr_ptr (0..NREQ-1).
- Output register drives the cdb_* outputs.
- Reset (async): full_i = 0, rr_ptr = 0, cdb_valid = 0, cdb_tag = 0, cdb_data = 0, cdb_ov = 0, cdb_src = 0, busy = 0.
  - Reset mid-operation drops all buffered results with no broadcast.
- Grant (combinational, from registered state only, no input-to-output path):
  - Scan full_i starting at index rr_ptr, wrapping modulo NREQ.
  - The first full buffer wins and gets grant_i = 1.
  - At most one grant per cycle; no grant if no buffer is full.
- Accept: req_ready_i = ~flush & (~full_i | grant_i).
  - A handshake occurs when req_valid_i & req_ready_i.
  - On a handshake, buffer i loads req_tag/req_data/req_ov at the edge and full_i = 1.
  - A unit being granted may push a new result in the same cycle (full_i stays 1 with the new contents), so one unit can sustain one result per cycle.
- Broadcast: on the edge after a grant:
  - cdb_valid = 1 and cdb_tag/data/ov are loaded from the granted buffer; cdb_src = winner index.
  - full_winner clears unless refilled the same cycle.
  - rr_ptr = (winner + 1) mod NREQ.
  - cdb_valid is high for exactly one cycle per result; with no grant, cdb_valid = 0 and the other cdb_* fields hold their old values.
- Latency: a handshake at edge E0 reaches the CDB at edge E1 at the earliest (1 cycle). Worst-case wait under contention is NREQ cycles.
- Fairness: a full buffer is granted within NREQ grants; no starvation.
- Flush (synchronous, highest priority):
  - At the edge, all full_i = 0 and cdb_valid = 0.
  - req_ready = 0 during the flush cycle, so no handshake occurs.
  - Any grant computed that cycle is discarded: no broadcast and rr_ptr is unchanged.
  - Flush together with req_valid drops the incoming results.
- Tags are not checked. Duplicate tags from different units are broadcast in grant order.
- busy = |full | cdb_valid, registered-state-derived.

Test Plan:
- Reset/idle:
  - Stimulus: reset asserted async mid-cycle while full = 3'b111.
  - Required: all outputs 0 immediately and after release, no broadcast.
- Single request:
  - Stimulus: unit 1 pushes tag=5, data=0x0000ABCD, ov=0 at edge E0.
  - Required: req_ready_1 = 1 in that cycle. After E1: cdb_valid = 1, tag = 5, data = 0xABCD, cdb_src = 1. After E2: cdb_valid = 0.
- Three-way contention:
  - Stimulus: all units push in the same cycle with rr_ptr = 0.
  - Required: broadcast order 0, 1, 2 on three consecutive cycles, then rr_ptr = 0. Repeat with rr_ptr = 2 and get order 2, 0, 1.
- Back-to-back same unit:
  - Stimulus: unit 2 holds req_valid for 4 cycles with tags 1..4 while the others are idle.
  - Required: req_ready_2 = 1 every cycle; CDB shows tags 1, 2, 3, 4 on consecutive cycles.
- Backpressure:
  - Stimulus: units 0 and 1 stream continuously.
  - Required: each unit gets ready every other cycle, grants alternate, and no result is lost or duplicated (scoreboard check).
- Flush:
  - Stimulus: full = 3'b101, cdb_valid = 1, flush = 1 with req_valid_1 = 1.
  - Required: req_ready = 0 in the flush cycle. Next cycle: full = 0, cdb_valid = 0, rr_ptr unchanged, and unit 1's result is never broadcast.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: holds one finished result per functional unit and broadcasts
// one per cycle on the registered common data bus, chosen round-robin.
module cdb_arbiter #(
  parameter int NREQ = 3,
  parameter int TAG_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*TAG_W-1:0]    req_tag,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic [NREQ-1:0]          req_ov,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_data,
  output logic                     cdb_ov,
  output logic [1:0]               cdb_src,
  output logic                     busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [NREQ-1:0]   full;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   push;
  logic [TAG_W-1:0]  buf_tag [NREQ];
  logic [DATA_W-1:0] buf_data [NREQ];
  logic [NREQ-1:0]   buf_ov;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     win;
  logic              any;
  int                best;
  // Winner is the full buffer at the smallest rotated distance from rr_ptr.
  always_comb begin
    any = 1'b0;
    win = '0;
    best = NREQ;
    for (int i = 0; i < NREQ; i++)
      if (full[i] && ((i + NREQ - int'(rr_ptr)) % NREQ) < best) begin
        any = 1'b1;
        win = PW'(i);
        best = (i + NREQ - int'(rr_ptr)) % NREQ;
      end
  end
  assign grant = any ? (NREQ'(1) << win) : '0;
  assign req_ready = {NREQ{~flush}} & (~full | grant);
  assign push = req_valid & req_ready;
  assign busy = |full | cdb_valid;
  always_ff @(posedge clock) begin
    for (int i = 0; i < NREQ; i++)
      if (push[i]) begin
        buf_tag[i] <= req_tag[i*TAG_W +: TAG_W];
        buf_data[i] <= req_data[i*DATA_W +: DATA_W];
        buf_ov[i] <= req_ov[i];
      end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full <= '0;
      rr_ptr <= '0;
      cdb_valid <= 1'b0;
      cdb_tag <= '0;
      cdb_data <= '0;
      cdb_ov <= 1'b0;
      cdb_src <= '0;
    end else if (flush) begin
      full <= '0;
      cdb_valid <= 1'b0;
    end else begin
      full <= (full & ~grant) | push;
      cdb_valid <= any;
      if (any) begin
        cdb_tag <= buf_tag[win];
        cdb_data <= buf_data[win];
        cdb_ov <= buf_ov[win];
        cdb_src <= 2'(win);
        rr_ptr <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios with hand-computed expectations for cdb_arbiter.
module tb_cdb_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [2:0]  req_ready;
  logic [11:0] req_tag = '0;
  logic [95:0] req_data = '0;
  logic [2:0]  req_ov = '0;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        cdb_ov;
  logic [1:0]  cdb_src;
  logic        busy;
  int vectors = 0;
  int miscompares = 0;

  cdb_arbiter #(.NREQ(3), .TAG_W(4), .DATA_W(32)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .req_data(req_data), .req_ov(req_ov), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_ov(cdb_ov),
    .cdb_src(cdb_src), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    req_valid = '0;
    flush = 1'b0;
  endtask

  task automatic drive(input int u, input logic [3:0] t, input logic [31:0] d, input logic o);
    req_valid[u] = 1'b1;
    req_tag[u*4 +: 4] = t;
    req_data[u*32 +: 32] = d;
    req_ov[u] = o;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    tick;
    vectors++;
    if ({cdb_valid, cdb_tag, cdb_data, cdb_ov, cdb_src, busy} !== 40'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %h want 0", {cdb_valid, cdb_tag, cdb_data, cdb_ov, cdb_src, busy});
    end
    reset = 1'b0;
    drive(0, 4'd1, 32'h11, 1'b1);
    drive(1, 4'd2, 32'h22, 1'b0);
    drive(2, 4'd3, 32'h33, 1'b1);
    #1;
    vectors++;
    if (req_ready !== 3'b111) begin
      miscompares++;
      $display("FAIL reset_idle_ready: got %b want 111", req_ready);
    end
    tick;
    idle;
    drive(0, 4'd4, 32'h44, 1'b0);
    #1;
    vectors++;
    if (req_ready !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_fill_ready: got %b want 001", req_ready);
    end
    tick;
    idle;
    vectors++;
    if ({cdb_valid, cdb_src, cdb_tag, cdb_data, cdb_ov, dut.full} !== {1'b1, 2'd0, 4'd1, 32'h11, 1'b1, 3'b111}) begin
      miscompares++;
      $display("FAIL reset_pre_bcast: got v=%b src=%0d tag=%h data=%h ov=%b full=%b want v=1 src=0 tag=1 data=11 ov=1 full=111",
               cdb_valid, cdb_src, cdb_tag, cdb_data, cdb_ov, dut.full);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({cdb_valid, cdb_tag, cdb_data, cdb_ov, cdb_src, busy, dut.full} !== 43'd0) begin
      miscompares++;
      $display("FAIL reset_async: got v=%b tag=%h data=%h ov=%b src=%0d busy=%b full=%b want all 0",
               cdb_valid, cdb_tag, cdb_data, cdb_ov, cdb_src, busy, dut.full);
    end
    tick;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick;
      vectors++;
      if ({cdb_valid, busy, cdb_tag} !== 6'd0) begin
        miscompares++;
        $display("FAIL reset_release_%0d: got v=%b busy=%b tag=%h want 0 0 0", k, cdb_valid, busy, cdb_tag);
      end
    end
  endtask

  task automatic test_single;
    drive(1, 4'd5, 32'h0000ABCD, 1'b0);
    #1;
    vectors++;
    if (req_ready[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ready: got %b want 1", req_ready[1]);
    end
    tick;
    idle;
    vectors++;
    if ({cdb_valid, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL single_e0: got v=%b busy=%b want v=0 busy=1", cdb_valid, busy);
    end
    tick;
    vectors++;
    if ({cdb_valid, cdb_tag, cdb_data, cdb_src, cdb_ov} !== {1'b1, 4'd5, 32'h0000ABCD, 2'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL single_e1: got v=%b tag=%h data=%h src=%0d ov=%b want v=1 tag=5 data=0000abcd src=1 ov=0",
               cdb_valid, cdb_tag, cdb_data, cdb_src, cdb_ov);
    end
    tick;
    vectors++;
    if ({cdb_valid, busy, cdb_tag} !== {1'b0, 1'b0, 4'd5}) begin
      miscompares++;
      $display("FAIL single_e2: got v=%b busy=%b tag=%h want v=0 busy=0 tag=5 held", cdb_valid, busy, cdb_tag);
    end
  endtask

  task automatic test_contention;
    logic [3:0] et;
    int eu;
    do_reset;
    drive(0, 4'hA, 32'hA0, 1'b0);
    drive(1, 4'hB, 32'hB0, 1'b1);
    drive(2, 4'hC, 32'hC0, 1'b0);
    tick;
    idle;
    for (int k = 0; k < 3; k++) begin
      tick;
      et = 4'(10 + k);
      vectors++;
      if ({cdb_valid, cdb_src, cdb_tag, cdb_ov} !== {1'b1, 2'(k), et, (k == 1)}) begin
        miscompares++;
        $display("FAIL contend_a_%0d: got v=%b src=%0d tag=%h ov=%b want v=1 src=%0d tag=%h ov=%b",
                 k, cdb_valid, cdb_src, cdb_tag, cdb_ov, k, et, k == 1);
      end
    end
    tick;
    vectors++;
    if ({cdb_valid, dut.rr_ptr} !== 3'b000) begin
      miscompares++;
      $display("FAIL contend_a_end: got v=%b rr=%0d want v=0 rr=0", cdb_valid, dut.rr_ptr);
    end
    drive(1, 4'h9, 32'h90, 1'b0);
    tick;
    idle;
    tick;
    vectors++;
    if ({cdb_valid, cdb_src, dut.rr_ptr} !== {1'b1, 2'd1, 2'd2}) begin
      miscompares++;
      $display("FAIL contend_prep: got v=%b src=%0d rr=%0d want v=1 src=1 rr=2", cdb_valid, cdb_src, dut.rr_ptr);
    end
    drive(0, 4'hD, 32'hD0, 1'b0);
    drive(1, 4'hE, 32'hE0, 1'b0);
    drive(2, 4'hF, 32'hF0, 1'b0);
    tick;
    idle;
    for (int k = 0; k < 3; k++) begin
      tick;
      eu = (2 + k) % 3;
      et = 4'(13 + eu);
      vectors++;
      if ({cdb_valid, cdb_src, cdb_tag} !== {1'b1, 2'(eu), et}) begin
        miscompares++;
        $display("FAIL contend_b_%0d: got v=%b src=%0d tag=%h want v=1 src=%0d tag=%h",
                 k, cdb_valid, cdb_src, cdb_tag, eu, et);
      end
    end
    tick;
    vectors++;
    if ({cdb_valid, dut.rr_ptr} !== {1'b0, 2'd2}) begin
      miscompares++;
      $display("FAIL contend_b_end: got v=%b rr=%0d want v=0 rr=2", cdb_valid, dut.rr_ptr);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] et;
    for (int k = 0; k < 4; k++) begin
      drive(2, 4'(k + 1), 32'(32'h200 + k), 1'b0);
      #1;
      vectors++;
      if (req_ready[2] !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready_%0d: got %b want 1", k, req_ready[2]);
      end
      tick;
      if (k > 0) begin
        et = 4'(k);
        vectors++;
        if ({cdb_valid, cdb_src, cdb_tag} !== {1'b1, 2'd2, et}) begin
          miscompares++;
          $display("FAIL b2b_cdb_%0d: got v=%b src=%0d tag=%h want v=1 src=2 tag=%h", k, cdb_valid, cdb_src, cdb_tag, et);
        end
      end
    end
    idle;
    tick;
    vectors++;
    if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 4'd4, 32'h203}) begin
      miscompares++;
      $display("FAIL b2b_last: got v=%b tag=%h data=%h want v=1 tag=4 data=203", cdb_valid, cdb_tag, cdb_data);
    end
    tick;
    vectors++;
    if (cdb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_done: got v=%b want 0", cdb_valid);
    end
  endtask

  task automatic test_backpressure;
    int sent [2];
    int got [2];
    int s;
    logic [1:0] er;
    logic pv;
    logic [1:0] ps;
    sent = '{0, 0};
    got = '{0, 0};
    pv = 1'b0;
    ps = '0;
    do_reset;
    for (int c = 0; c < 14; c++) begin
      if (c < 10) begin
        for (int u = 0; u < 2; u++)
          drive(u, 4'(u * 8 + sent[u]), 32'(u * 256 + sent[u]), 1'b0);
        #1;
        er = (c == 0) ? 2'b11 : ((c % 2 == 1) ? 2'b01 : 2'b10);
        vectors++;
        if (req_ready[1:0] !== er) begin
          miscompares++;
          $display("FAIL bp_ready_c%0d: got %b want %b", c, req_ready[1:0], er);
        end
        for (int u = 0; u < 2; u++)
          if (req_ready[u]) sent[u]++;
      end else begin
        idle;
      end
      tick;
      if (cdb_valid) begin
        s = int'(cdb_src);
        vectors++;
        if (s > 1 || cdb_data !== 32'(s * 256 + got[s]) || (pv && cdb_src === ps)) begin
          miscompares++;
          $display("FAIL bp_bcast_c%0d: got src=%0d data=%h prev_src=%0d want alternating src, data=%h",
                   c, cdb_src, cdb_data, ps, 32'(s * 256 + ((s > 1) ? 0 : got[s])));
        end
        if (s <= 1) got[s]++;
      end
      pv = cdb_valid;
      ps = cdb_src;
    end
    vectors++;
    if (got[0] != 6 || got[1] != 5 || sent[0] != 6 || sent[1] != 5) begin
      miscompares++;
      $display("FAIL bp_scoreboard: got sent=%0d/%0d bcast=%0d/%0d want sent=6/5 bcast=6/5",
               sent[0], sent[1], got[0], got[1]);
    end
  endtask

  task automatic test_flush;
    logic seen;
    do_reset;
    drive(0, 4'd1, 32'h1, 1'b0);
    drive(1, 4'd2, 32'h2, 1'b0);
    drive(2, 4'd3, 32'h3, 1'b0);
    tick;
    idle;
    tick;
    drive(0, 4'd4, 32'h4, 1'b0);
    tick;
    idle;
    vectors++;
    if ({cdb_valid, cdb_src, dut.full, dut.rr_ptr} !== {1'b1, 2'd1, 3'b101, 2'd2}) begin
      miscompares++;
      $display("FAIL flush_pre: got v=%b src=%0d full=%b rr=%0d want v=1 src=1 full=101 rr=2",
               cdb_valid, cdb_src, dut.full, dut.rr_ptr);
    end
    flush = 1'b1;
    drive(1, 4'hE, 32'hDEAD, 1'b1);
    #1;
    vectors++;
    if (req_ready !== 3'b000) begin
      miscompares++;
      $display("FAIL flush_ready: got %b want 000", req_ready);
    end
    tick;
    idle;
    vectors++;
    if ({cdb_valid, busy, dut.full, dut.rr_ptr} !== {1'b0, 1'b0, 3'b000, 2'd2}) begin
      miscompares++;
      $display("FAIL flush_after: got v=%b busy=%b full=%b rr=%0d want v=0 busy=0 full=000 rr=2",
               cdb_valid, busy, dut.full, dut.rr_ptr);
    end
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      seen = seen | cdb_valid;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_dropped: got broadcast=%b tag=%h want no broadcast", seen, cdb_tag);
    end
    drive(1, 4'd7, 32'h77, 1'b0);
    tick;
    idle;
    tick;
    vectors++;
    if ({cdb_valid, cdb_src, cdb_tag, cdb_data} !== {1'b1, 2'd1, 4'd7, 32'h77}) begin
      miscompares++;
      $display("FAIL flush_resume: got v=%b src=%0d tag=%h data=%h want v=1 src=1 tag=7 data=77",
               cdb_valid, cdb_src, cdb_tag, cdb_data);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_back_to_back;
    test_backpressure;
    test_flush;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
